// File: rtl/fight_controller.sv
// Round controller for a two-player fighting game.
// Steps an IDLE -> READY -> FIGHT -> KO round sequence once per video frame.
// In FIGHT it detects landed punches, applies saturating damage, and
// declares a winner when a health value reaches zero.
module fight_controller #(
    parameter logic [6:0] HP_MAX       = 7'd100,
    parameter logic [6:0] DAMAGE       = 7'd10,
    parameter logic [9:0] REACH        = 10'd70,
    parameter logic [7:0] READY_FRAMES = 8'd60,
    parameter logic [7:0] KO_FRAMES    = 8'd120
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       start,
    input  logic [9:0] p1x,
    input  logic [9:0] p2x,
    input  logic [9:0] action1,
    input  logic [9:0] action2,
    input  logic [9:0] direction1,
    input  logic [9:0] direction2,
    output logic [6:0] hp1,
    output logic [6:0] hp2,
    output logic [1:0] state,
    output logic       move_enable,
    output logic [1:0] winner,
    output logic       hit1,
    output logic       hit2
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READY = 2'd1;
    localparam logic [1:0] S_FIGHT = 2'd2;
    localparam logic [1:0] S_KO    = 2'd3;

    // Sprite action code of the frame in which a punch is extended.
    localparam logic [9:0] PUNCH_CODE = 10'd13;

    logic       frame_d;
    logic       tick;
    logic [7:0] timer;
    logic       armed1;
    logic       armed2;

    logic       p2_on_right;
    logic       p1_on_right;
    logic [9:0] dist_p2_minus_p1;
    logic [9:0] dist_p1_minus_p2;
    logic       reach1;
    logic       reach2;
    logic       land1;
    logic       land2;
    logic [6:0] hp1_after;
    logic [6:0] hp2_after;

    // Only bit 0 of each direction code carries facing information.
    logic unused_direction_bits;
    assign unused_direction_bits = ^{direction1[9:1], direction2[9:1]};

    // Frame strobe rising-edge detector: tick is a one-Clk pulse per frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (!Reset_n) begin
            frame_d <= 1'b0;
            tick    <= 1'b0;
        end else begin
            frame_d <= frame_clk;
            tick    <= frame_clk & ~frame_d;
        end
    end

    // Reach and facing test; distances are formed only after the ordering
    // compare so an unsigned subtraction can never wrap into a small value.
    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no
        // latch is inferred.
        p2_on_right      = (p2x >= p1x);
        p1_on_right      = (p1x >= p2x);
        dist_p2_minus_p1 = p2_on_right ? (p2x - p1x) : 10'd0;
        dist_p1_minus_p2 = p1_on_right ? (p1x - p2x) : 10'd0;

        reach1 = direction1[0] ? (p2_on_right && (dist_p2_minus_p1 <= REACH))
                               : (p1_on_right && (dist_p1_minus_p2 <= REACH));
        reach2 = direction2[0] ? (p1_on_right && (dist_p1_minus_p2 <= REACH))
                               : (p2_on_right && (dist_p2_minus_p1 <= REACH));

        land1 = (state == S_FIGHT) && (action1 == PUNCH_CODE) && armed1 && reach1;
        land2 = (state == S_FIGHT) && (action2 == PUNCH_CODE) && armed2 && reach2;

        hp1_after = hp1;
        hp2_after = hp2;
        if (land2) begin
            hp1_after = (hp1 <= DAMAGE) ? 7'd0 : (hp1 - DAMAGE);
        end
        if (land1) begin
            hp2_after = (hp2 <= DAMAGE) ? 7'd0 : (hp2 - DAMAGE);
        end
    end

    // Punch arming: a punch re-arms only once the player leaves the punch
    // frame, so holding the punch pose deals damage a single time.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            armed1 <= 1'b1;
            armed2 <= 1'b1;
        end else if (tick) begin
            if (action1 != PUNCH_CODE) begin
                armed1 <= 1'b1;
            end else if (land1) begin
                armed1 <= 1'b0;
            end
            if (action2 != PUNCH_CODE) begin
                armed2 <= 1'b1;
            end else if (land2) begin
                armed2 <= 1'b0;
            end
        end
    end

    // Round sequencer: state, timer, health, winner, hit pulses and the
    // movement gate, which is registered alongside the state it decodes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            timer       <= 8'd0;
            hp1         <= HP_MAX;
            hp2         <= HP_MAX;
            winner      <= 2'd0;
            move_enable <= 1'b0;
            hit1        <= 1'b0;
            hit2        <= 1'b0;
        end else begin
            // Hit outputs are single-cycle pulses; they default low.
            hit1 <= 1'b0;
            hit2 <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        hp1   <= HP_MAX;
                        hp2   <= HP_MAX;
                        timer <= 8'd0;
                        if (start) begin
                            state  <= S_READY;
                            winner <= 2'd0;
                        end
                    end
                    S_READY: begin
                        if (timer == READY_FRAMES - 8'd1) begin
                            state       <= S_FIGHT;
                            timer       <= 8'd0;
                            move_enable <= 1'b1;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                    S_FIGHT: begin
                        hit1 <= land1;
                        hit2 <= land2;
                        hp1  <= hp1_after;
                        hp2  <= hp2_after;
                        if ((hp1_after == 7'd0) || (hp2_after == 7'd0)) begin
                            state       <= S_KO;
                            timer       <= 8'd0;
                            move_enable <= 1'b0;
                            // Bit 1 flags player 1 down, bit 0 player 2 down,
                            // which yields 1 / 2 / 3 for P1 win / P2 win / draw.
                            winner      <= {hp1_after == 7'd0, hp2_after == 7'd0};
                        end
                    end
                    S_KO: begin
                        if (timer == KO_FRAMES - 8'd1) begin
                            state <= S_IDLE;
                            timer <= 8'd0;
                            hp1   <= HP_MAX;
                            hp2   <= HP_MAX;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fight_controller.sv
// Scoreboard bench for fight_controller: the stimulus thread pushes the
// expected post-frame outputs, a monitor thread pops and compares them when
// the DUT presents the result of each frame tick.
module tb_fight_controller;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READY = 2'd1;
    localparam logic [1:0] FIGHT = 2'd2;
    localparam logic [1:0] KO    = 2'd3;

    logic       Clk;
    logic       Reset_n;
    logic       frame_clk;
    logic       start;
    logic [9:0] p1x;
    logic [9:0] p2x;
    logic [9:0] action1;
    logic [9:0] action2;
    logic [9:0] direction1;
    logic [9:0] direction2;
    logic [6:0] hp1;
    logic [6:0] hp2;
    logic [1:0] state;
    logic       move_enable;
    logic [1:0] winner;
    logic       hit1;
    logic       hit2;

    fight_controller dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .start       (start),
        .p1x         (p1x),
        .p2x         (p2x),
        .action1     (action1),
        .action2     (action2),
        .direction1  (direction1),
        .direction2  (direction2),
        .hp1         (hp1),
        .hp2         (hp2),
        .state       (state),
        .move_enable (move_enable),
        .winner      (winner),
        .hit1        (hit1),
        .hit2        (hit2)
    );

    typedef struct {
        logic [1:0] st;
        logic [6:0] hp1;
        logic [6:0] hp2;
        logic [1:0] win;
        logic       me;
        logic       h1;
        logic       h2;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".state"},       32'(state),       32'(IDLE));
        check({tag, ".hp1"},         32'(hp1),         32'd100);
        check({tag, ".hp2"},         32'(hp2),         32'd100);
        check({tag, ".winner"},      32'(winner),      32'd0);
        check({tag, ".move_enable"}, 32'(move_enable), 32'd0);
        check({tag, ".hit1"},        32'(hit1),        32'd0);
        check({tag, ".hit2"},        32'(hit2),        32'd0);
    endtask

    // Issue one frame strobe (called at a falling Clk edge) and queue the
    // outputs the DUT must show once that frame's tick has been processed.
    task automatic frame(input logic [1:0] st, input int e1, input int e2,
                         input logic [1:0] w, input logic h1, input logic h2,
                         input string tag);
        exp_t e;
        e.st  = st;
        e.hp1 = 7'(e1);
        e.hp2 = 7'(e2);
        e.win = w;
        e.me  = (st == FIGHT);
        e.h1  = h1;
        e.h2  = h2;
        e.tag = tag;
        exp_q.push_back(e);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    // Monitor: the tick is registered one edge after the strobe rises and
    // acted upon at the following edge; compare at the falling edge after
    // that, then confirm the hit pulses lasted a single cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            @(posedge Clk);
            @(posedge Clk);
            @(negedge Clk);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL queue_underflow: frame result with no expected entry (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, ".state"},       32'(state),       32'(e.st));
                check({e.tag, ".hp1"},         32'(hp1),         32'(e.hp1));
                check({e.tag, ".hp2"},         32'(hp2),         32'(e.hp2));
                check({e.tag, ".winner"},      32'(winner),      32'(e.win));
                check({e.tag, ".move_enable"}, 32'(move_enable), 32'(e.me));
                check({e.tag, ".hit1"},        32'(hit1),        32'(e.h1));
                check({e.tag, ".hit2"},        32'(hit2),        32'(e.h2));
                @(negedge Clk);
                check({e.tag, ".hit1_width"},  32'(hit1),        32'd0);
                check({e.tag, ".hit2_width"},  32'(hit2),        32'd0);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL timeout: bench did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int e_hp;

        Reset_n    = 1'b1;
        frame_clk  = 1'b0;
        start      = 1'b0;
        p1x        = 10'd100;
        p2x        = 10'd150;
        action1    = 10'd0;
        action2    = 10'd0;
        direction1 = 10'd1;
        direction2 = 10'd0;

        // Power-on reset, checked between clock edges.
        #3 Reset_n = 1'b0;
        #4 check_reset("por");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        check_reset("post_release");

        // Round 1: idle without start, then countdown with start held.
        frame(IDLE, 100, 100, 2'd0, 1'b0, 1'b0, "idle_no_start");
        start = 1'b1;
        frame(READY, 100, 100, 2'd0, 1'b0, 1'b0, "r1_start");
        for (int i = 1; i <= 60; i++) begin
            frame((i == 60) ? FIGHT : READY, 100, 100, 2'd0, 1'b0, 1'b0, "r1_ready");
        end
        start = 1'b0;

        // Single hit, held punch frame, re-arm and second hit.
        action1 = 10'd13;
        frame(FIGHT, 100, 90, 2'd0, 1'b1, 1'b0, "hit_first");
        for (int i = 0; i < 4; i++) begin
            frame(FIGHT, 100, 90, 2'd0, 1'b0, 1'b0, "hit_held");
        end
        action1 = 10'd9;
        frame(FIGHT, 100, 90, 2'd0, 1'b0, 1'b0, "rearm");
        action1 = 10'd13;
        frame(FIGHT, 100, 80, 2'd0, 1'b1, 1'b0, "hit_second");

        // Reach boundary: 71 pixels misses, 70 lands.
        action1 = 10'd0;
        frame(FIGHT, 100, 80, 2'd0, 1'b0, 1'b0, "arm_a");
        action1 = 10'd13;
        p2x     = 10'd171;
        frame(FIGHT, 100, 80, 2'd0, 1'b0, 1'b0, "reach_71");
        p2x     = 10'd170;
        frame(FIGHT, 100, 70, 2'd0, 1'b1, 1'b0, "reach_70");

        // Facing away from the opponent never lands.
        action1 = 10'd0;
        p2x     = 10'd150;
        frame(FIGHT, 100, 70, 2'd0, 1'b0, 1'b0, "arm_b");
        action1    = 10'd13;
        direction1 = 10'd0;
        frame(FIGHT, 100, 70, 2'd0, 1'b0, 1'b0, "wrong_facing");

        // Player 2 (facing left) hits player 1, then player 1 hits while
        // player 2 still holds the punch frame.
        action1    = 10'd0;
        direction1 = 10'd1;
        action2    = 10'd13;
        frame(FIGHT, 90, 70, 2'd0, 1'b0, 1'b1, "p2_hit");
        action1 = 10'd13;
        frame(FIGHT, 90, 60, 2'd0, 1'b1, 1'b0, "p1_hit_p2_held");

        // Mid-round reset, asserted and checked between clock edges.
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1 check_reset("mid_round");
        repeat (2) @(negedge Clk);
        check_reset("mid_round_hold");
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        check_reset("mid_round_release");

        // Round 2: both punch frames held since before reset; reset must
        // have re-armed both players, so both land on the first fight tick.
        start = 1'b1;
        frame(READY, 100, 100, 2'd0, 1'b0, 1'b0, "r2_start");
        for (int i = 1; i <= 60; i++) begin
            frame((i == 60) ? FIGHT : READY, 100, 100, 2'd0, 1'b0, 1'b0, "r2_ready");
        end
        start = 1'b0;
        frame(FIGHT, 90, 90, 2'd0, 1'b1, 1'b1, "r2_armed_by_reset");

        // Player 1 punches player 2 down to zero; the last hit saturates.
        action2 = 10'd0;
        e_hp    = 90;
        for (int k = 1; k <= 9; k++) begin
            action1 = 10'd0;
            frame(FIGHT, 90, e_hp, 2'd0, 1'b0, 1'b0, "r2_arm");
            action1 = 10'd13;
            e_hp    = e_hp - 10;
            if (e_hp == 0) begin
                frame(KO, 90, 0, 2'd1, 1'b1, 1'b0, "r2_ko");
            end else begin
                frame(FIGHT, 90, e_hp, 2'd0, 1'b1, 1'b0, "r2_hit");
            end
        end

        // KO hold: start and punches ignored, then IDLE with health restored
        // and the winner kept.
        start = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            action1 = (i % 2 == 1) ? 10'd13 : 10'd0;
            if (i == 120) begin
                frame(IDLE, 100, 100, 2'd1, 1'b0, 1'b0, "ko_to_idle");
            end else begin
                frame(KO, 90, 0, 2'd1, 1'b0, 1'b0, "ko_hold");
            end
        end

        // Round 3: winner cleared on start; simultaneous hits to a draw.
        action1 = 10'd0;
        action2 = 10'd0;
        frame(READY, 100, 100, 2'd0, 1'b0, 1'b0, "r3_start");
        for (int i = 1; i <= 60; i++) begin
            frame((i == 60) ? FIGHT : READY, 100, 100, 2'd0, 1'b0, 1'b0, "r3_ready");
        end
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            e_hp    = 100 - 10 * k;
            action1 = 10'd13;
            action2 = 10'd13;
            frame((k == 10) ? KO : FIGHT, e_hp, e_hp, (k == 10) ? 2'd3 : 2'd0,
                  1'b1, 1'b1, "simul_hit");
            action1 = 10'd0;
            action2 = 10'd0;
            frame((k == 10) ? KO : FIGHT, e_hp, e_hp, (k == 10) ? 2'd3 : 2'd0,
                  1'b0, 1'b0, "simul_release");
        end

        repeat (4) @(negedge Clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fight_controller.md
FIGHT_CONTROLLER -- requirements
Module: fight_controller

Interface
REQ-001 SHALL have parameter HP_MAX, default 7'd100, meaning starting health of each player.
REQ-002 SHALL have parameter DAMAGE, default 7'd10, meaning health removed per landed punch.
REQ-003 SHALL have parameter REACH, default 10'd70, meaning maximum horizontal distance in pixels at which a punch lands.
REQ-004 SHALL have parameter READY_FRAMES, default 8'd60, meaning the countdown length in frames before a round.
REQ-005 SHALL have parameter KO_FRAMES, default 8'd120, meaning the hold length in frames after a knockout.
REQ-006 SHALL have port Clk, input, 1 bit, the single system clock.
REQ-007 SHALL have port Reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-008 SHALL have port frame_clk, input, 1 bit, the vertical-sync frame strobe, which is asynchronous to game logic.
REQ-009 SHALL have port start, input, 1 bit, a level request to begin a round.
REQ-010 SHALL have ports p1x and p2x, input, 10 bits each, the players' left-edge x positions.
REQ-011 SHALL have ports action1 and action2, input, 10 bits each, the players' sprite action codes.
REQ-012 SHALL have ports direction1 and direction2, input, 10 bits each: bit0 = 1 means facing right, 0 means facing left.
REQ-013 SHALL have ports hp1 and hp2, output, 7 bits each, the current health values.
REQ-014 SHALL have port state, output, 2 bits, the round state: IDLE = 0, READY = 1, FIGHT = 2, KO = 3.
REQ-015 SHALL have port move_enable, output, 1 bit, which gates player movement; it is 1 only in FIGHT.
REQ-016 SHALL have port winner, output, 2 bits: 0 = none, 1 = player 1, 2 = player 2, 3 = draw.
REQ-017 SHALL have ports hit1 and hit2, output, 1 bit each; each is a one-Clk pulse when that player's punch lands.

Function
REQ-018 SHALL detect the frame_clk rising edge by sampling frame_clk into a delay flop and registering tick = frame_clk & ~delayed; tick SHALL be high for exactly one Clk cycle per frame.
REQ-019 SHALL change all state, timer, hp, winner and armed registers only on Clk cycles where tick = 1.
REQ-020 In IDLE: hp1 = hp2 = HP_MAX, timer = 0, move_enable = 0; if start = 1 on a tick, go to READY and clear winner.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 In READY: timer increments once per tick; on the tick where timer == READY_FRAMES-1, go to FIGHT with timer = 0.
REQ-023 In FIGHT: the punch-active frame is action code 10'd13; player 1 lands on a tick when all of the following hold:
  - action1 == 13
  - armed1 = 1
  - facing condition: direction1[0] = 1 with p2x >= p1x and (p2x - p1x) <= REACH, or direction1[0] = 0 with p1x >= p2x and (p1x - p2x) <= REACH.
  Player 2 lands under the same rules with the indices swapped.
REQ-024 SHALL compute distances as 10-bit unsigned values, subtracting only after the ordering compare so that no wrap-around occurs.
REQ-025 armedN SHALL be cleared on the tick that playerN lands, and set on any tick where actionN != 13; each punch therefore deals damage at most once.
REQ-026 A landing by player 1 SHALL update hp2 with a saturating subtract: hp2 <= (hp2 <= DAMAGE) ? 0 : hp2 - DAMAGE; landings by player 2 update hp1 symmetrically.
REQ-027 When both players land on the same tick, both damages SHALL apply and both hit1 and hit2 SHALL pulse on that cycle.
REQ-028 On the tick where the post-damage hp1 or hp2 is 0, the block SHALL go to KO with timer = 0.
  - winner = 1 if only hp2 is 0.
  - winner = 2 if only hp1 is 0.
  - winner = 3 if both are 0.
REQ-029 In KO: move_enable = 0, hp values are held, and no hit detection occurs; on the tick where timer == KO_FRAMES-1, go to IDLE, restore hp to HP_MAX, and hold winner.
REQ-030 hit1 and hit2 SHALL be 0 outside FIGHT.
REQ-031 move_enable SHALL be a registered decode of state, with no combinational path from any input.

Reset
REQ-032 On assertion of Reset_n = 0, regardless of the Clk edge or the current state, the block SHALL asynchronously set:
  - state = IDLE
  - hp1 = hp2 = HP_MAX
  - winner = 0, timer = 0
  - armed1 = armed2 = 1
  - hit1 = hit2 = 0, move_enable = 0
  - frame-edge flops = 0
REQ-033 The first tick after Reset_n deasserts SHALL be processed normally; no tick is generated by reset release itself.

Verification
REQ-034 Round start: start = 1 in IDLE, then 60 ticks -> state READY for 60 ticks, then FIGHT with move_enable = 1.
REQ-035 Single hit: p1x = 100, p2x = 150, direction1 = 1, action1 held at 13 for 5 ticks -> exactly one hit1 pulse and hp2 = 90; repeating the punch after action1 = 9 gives hp2 = 80.
REQ-036 Out of range and wrong facing:
  - p2x - p1x = 71 with action1 = 13 -> no hit and hp2 = 100.
  - direction1 = 0 with p2x > p1x -> no hit.
REQ-037 Simultaneous hits: both players at 13 and in range on the same tick with hp1 = hp2 = 10 -> hit1 = hit2 = 1, both hp = 0, state KO, winner = 3.
REQ-038 KO and recovery: hp2 = 5 when player 1 lands -> hp2 = 0, winner = 1; after 120 ticks, state IDLE with hp = 100 and winner still 1.
REQ-039 Mid-round reset: Reset_n pulsed low between Clk edges during FIGHT -> all outputs at reset values immediately, without waiting for a Clk edge.
